// File: rtl/spi_regbank_slave.sv
// SPI slave exposing NUM_REGS registers of DATA_W bits, fully oversampled on clk.
// Frames are ADDR_W address bits (MSB = write flag) followed by DATA_W data bits, MSB first.
module spi_regbank_slave #(
  parameter int                           DATA_W       = 32,
  parameter int                           ADDR_W       = 8,
  parameter int                           NUM_REGS     = 4,
  parameter bit                           CPOL         = 1'b0,
  parameter bit                           CPHA         = 1'b0,
  parameter logic [NUM_REGS*DATA_W-1:0]   RESET_VALUES = {32'd4567890, 32'd3456789, 32'd2345678, 32'd1234567},
  parameter logic [NUM_REGS-1:0]          RO_MASK      = '0
) (
  input  logic                         clk,
  input  logic                         i_Rst_L,
  input  logic                         i_SPI_Clk,
  input  logic                         i_SPI_MOSI,
  input  logic                         i_SPI_CS_n,
  output logic                         o_SPI_MISO,
  output logic                         o_SPI_MISO_En,
  output logic [NUM_REGS*DATA_W-1:0]   o_regs,
  input  logic [NUM_REGS*DATA_W-1:0]   i_status,
  output logic [NUM_REGS-1:0]          o_wr_strobe,
  output logic [NUM_REGS-1:0]          o_rd_strobe,
  output logic                         o_frame_err
);

  localparam int CNT_W  = $clog2(ADDR_W + DATA_W + 1);
  localparam int IDX_W  = ADDR_W - 1;
  localparam bit SAMPLE_ON_RISE = (CPOL == CPHA);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DONE, S_WAIT_CS} state_t;

  logic [1:0]                        r_sck_sync;
  logic [1:0]                        r_cs_sync;
  logic [1:0]                        r_mosi_sync;
  logic                              r_sck_prev;
  logic                              r_cs_prev;
  logic                              r_mosi_d;
  logic                              r_sample_ev;
  logic                              r_shift_ev;
  logic                              r_cs_fall_ev;
  logic                              r_cs_rise_ev;

  state_t                            r_state;
  logic [CNT_W-1:0]                  r_bit_cnt;
  logic [ADDR_W-1:0]                 r_addr;
  logic [DATA_W-2:0]                 r_rx;
  logic [DATA_W-1:0]                 r_tx;
  logic [NUM_REGS-1:0][DATA_W-1:0]   r_regs;
  logic [NUM_REGS-1:0]               r_wr_strobe;
  logic [NUM_REGS-1:0]               r_rd_strobe;
  logic                              r_frame_err;
  logic                              r_miso;
  logic                              r_miso_en;

  logic                              w_sck_rise;
  logic                              w_sck_fall;
  logic [ADDR_W-1:0]                 w_addr_full;
  logic [DATA_W-1:0]                 w_rx_full;
  logic [DATA_W-1:0]                 w_snap;
  logic [NUM_REGS-1:0]               w_rd_hit;
  logic [NUM_REGS-1:0]               w_wr_hit;

  assign w_sck_rise  = r_sck_sync[1] & ~r_sck_prev;
  assign w_sck_fall  = ~r_sck_sync[1] & r_sck_prev;
  assign w_addr_full = {r_addr[ADDR_W-2:0], r_mosi_d};
  assign w_rx_full   = {r_rx, r_mosi_d};

  // Synchronisers keep sampling through reset so the CS_n level is valid on reset exit
  always_ff @(posedge clk) begin
    r_sck_sync  <= {r_sck_sync[0], i_SPI_Clk};
    r_cs_sync   <= {r_cs_sync[0], i_SPI_CS_n};
    r_mosi_sync <= {r_mosi_sync[0], i_SPI_MOSI};
    r_sck_prev  <= r_sck_sync[1];
    r_cs_prev   <= r_cs_sync[1];
    r_mosi_d    <= r_mosi_sync[1];
    if (!i_Rst_L) begin
      r_sample_ev  <= 1'b0;
      r_shift_ev   <= 1'b0;
      r_cs_fall_ev <= 1'b0;
      r_cs_rise_ev <= 1'b0;
    end else begin
      r_sample_ev  <= SAMPLE_ON_RISE ? w_sck_rise : w_sck_fall;
      r_shift_ev   <= SAMPLE_ON_RISE ? w_sck_fall : w_sck_rise;
      r_cs_fall_ev <= ~r_cs_sync[1] & r_cs_prev;
      r_cs_rise_ev <= r_cs_sync[1] & ~r_cs_prev;
    end
  end

  // Address decode: read snapshot source and write target
  always_comb begin
    w_snap   = '1;
    w_rd_hit = '0;
    w_wr_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!w_addr_full[ADDR_W-1] && (w_addr_full[ADDR_W-2:0] == IDX_W'(i))) begin
        w_rd_hit[i] = 1'b1;
        w_snap      = RO_MASK[i] ? i_status[i*DATA_W +: DATA_W] : r_regs[i];
      end else begin
        w_rd_hit[i] = 1'b0;
      end
      if (r_addr[ADDR_W-1] && (r_addr[ADDR_W-2:0] == IDX_W'(i)) && !RO_MASK[i]) begin
        w_wr_hit[i] = 1'b1;
      end else begin
        w_wr_hit[i] = 1'b0;
      end
    end
  end

  // Frame FSM, register bank, strobes and MISO driver
  always_ff @(posedge clk) begin
    if (!i_Rst_L) begin
      r_state     <= r_cs_prev ? S_IDLE : S_WAIT_CS;
      r_bit_cnt   <= '0;
      r_addr      <= '0;
      r_rx        <= '0;
      r_tx        <= '1;
      r_regs      <= RESET_VALUES;
      r_wr_strobe <= '0;
      r_rd_strobe <= '0;
      r_frame_err <= 1'b0;
      r_miso      <= 1'b1;
      r_miso_en   <= 1'b0;
    end else begin
      r_wr_strobe <= '0;
      r_rd_strobe <= '0;
      r_frame_err <= 1'b0;
      r_miso_en   <= ~r_cs_prev;
      case (r_state)
        S_IDLE: begin
          r_miso <= 1'b1;
          if (r_cs_fall_ev) begin
            r_state   <= S_ADDR;
            r_bit_cnt <= '0;
          end
        end
        S_ADDR: begin
          r_miso <= 1'b1;
          if (r_cs_rise_ev) begin
            r_frame_err <= 1'b1;
            r_state     <= S_IDLE;
          end else if (r_sample_ev) begin
            r_addr    <= w_addr_full;
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == CNT_W'(ADDR_W - 1)) begin
              r_state     <= S_DATA;
              r_rd_strobe <= w_rd_hit;
              // CPHA=0 must present the MSB before the first data sample edge
              if (CPHA) begin
                r_tx <= w_snap;
              end else begin
                r_tx   <= w_snap << 1;
                r_miso <= w_snap[DATA_W-1];
              end
            end
          end
        end
        S_DATA: begin
          if (r_sample_ev && (r_bit_cnt == CNT_W'(ADDR_W + DATA_W - 1))) begin
            r_bit_cnt   <= r_bit_cnt + CNT_W'(1);
            r_rx        <= w_rx_full[DATA_W-2:0];
            r_wr_strobe <= w_wr_hit;
            r_miso      <= 1'b1;
            r_state     <= r_cs_rise_ev ? S_IDLE : S_DONE;
            for (int i = 0; i < NUM_REGS; i++) begin
              if (w_wr_hit[i]) r_regs[i] <= w_rx_full;
            end
          end else if (r_cs_rise_ev) begin
            r_frame_err <= 1'b1;
            r_miso      <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            if (r_sample_ev) begin
              r_rx      <= w_rx_full[DATA_W-2:0];
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            // With CPHA=0 the shift edge right after the last address bit keeps the preloaded MSB
            if (r_shift_ev && (CPHA || (r_bit_cnt != CNT_W'(ADDR_W)))) begin
              r_miso <= r_tx[DATA_W-1];
              r_tx   <= r_tx << 1;
            end
          end
        end
        S_DONE: begin
          r_miso <= 1'b1;
          if (r_cs_rise_ev) r_state <= S_IDLE;
        end
        S_WAIT_CS: begin
          r_miso <= 1'b1;
          if (r_cs_prev) r_state <= S_IDLE;
        end
        default: begin
          r_miso  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_out
    assign o_regs[gi*DATA_W +: DATA_W] = RO_MASK[gi] ? i_status[gi*DATA_W +: DATA_W] : r_regs[gi];
  end

  assign o_SPI_MISO    = r_miso;
  assign o_SPI_MISO_En = r_miso_en;
  assign o_wr_strobe   = r_wr_strobe;
  assign o_rd_strobe   = r_rd_strobe;
  assign o_frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_regbank_slave.sv
// Directed bench for spi_regbank_slave: one instance per SPI mode, reg 3 read-only.
module tb_spi_regbank_slave;

  localparam int H = 80;
  localparam logic [127:0] RST_VIEW = {32'hA5A5A5A5, 32'd3456789, 32'd2345678, 32'd1234567};

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   sck;
  logic [3:0]   cs_n;
  logic         mosi;
  logic [127:0] status;
  logic [3:0]   miso;
  logic [3:0]   miso_en;
  logic [3:0]   frame_err;
  logic [127:0] regs_o [4];
  logic [3:0]   wr_str [4];
  logic [3:0]   rd_str [4];

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt [4][4] = '{default: 0};
  int rd_cnt [4][4] = '{default: 0};
  int fe_cnt [4]    = '{default: 0};
  int wr_base [4][4];
  int rd_base [4][4];
  int fe_base [4];

  logic [31:0] rx_word;
  logic        addr_ones;
  logic        en_seen;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_regbank_slave #(
      .CPOL(1'(g / 2)),
      .CPHA(1'(g % 2)),
      .RO_MASK(4'b1000)
    ) u_dut (
      .clk(clk),
      .i_Rst_L(rst_n),
      .i_SPI_Clk(sck[g]),
      .i_SPI_MOSI(mosi),
      .i_SPI_CS_n(cs_n[g]),
      .o_SPI_MISO(miso[g]),
      .o_SPI_MISO_En(miso_en[g]),
      .o_regs(regs_o[g]),
      .i_status(status),
      .o_wr_strobe(wr_str[g]),
      .o_rd_strobe(rd_str[g]),
      .o_frame_err(frame_err[g])
    );
  end

  // Strobe pulse counters (cycles high per bit)
  always @(posedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (frame_err[m]) fe_cnt[m] <= fe_cnt[m] + 1;
      for (int i = 0; i < 4; i++) begin
        if (wr_str[m][i]) wr_cnt[m][i] <= wr_cnt[m][i] + 1;
        if (rd_str[m][i]) rd_cnt[m][i] <= rd_cnt[m][i] + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap_counts();
    for (int m = 0; m < 4; m++) begin
      fe_base[m] = fe_cnt[m];
      for (int i = 0; i < 4; i++) begin
        wr_base[m][i] = wr_cnt[m][i];
        rd_base[m][i] = rd_cnt[m][i];
      end
    end
  endtask

  // Bits whose strobe was high exactly one cycle since the snapshot
  function automatic logic [3:0] d_mask(input int m, input bit is_wr);
    logic [3:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      if (is_wr) r[i] = ((wr_cnt[m][i] - wr_base[m][i]) == 1);
      else       r[i] = ((rd_cnt[m][i] - rd_base[m][i]) == 1);
    end
    return r;
  endfunction

  function automatic int d_total(input int m, input bit is_wr);
    int t = 0;
    for (int i = 0; i < 4; i++) begin
      if (is_wr) t += wr_cnt[m][i] - wr_base[m][i];
      else       t += rd_cnt[m][i] - rd_base[m][i];
    end
    return t;
  endfunction

  task automatic spi_bits(input int m, input logic [39:0] frame, input int first, input int last);
    logic cpol;
    logic cpha;
    cpol = (m >= 2);
    cpha = ((m % 2) == 1);
    for (int k = first; k < last; k++) begin
      if (!cpha) begin
        mosi = frame[39-k];
        #(H);
        sck[m] = ~cpol;
      end else begin
        sck[m] = ~cpol;
        mosi = frame[39-k];
        #(H);
        sck[m] = cpol;
      end
      if (k == 0) en_seen = miso_en[m];
      if (k < 8) addr_ones = addr_ones & miso[m];
      else       rx_word = {rx_word[30:0], miso[m]};
      #(H);
      if (!cpha) sck[m] = cpol;
    end
  endtask

  task automatic spi_xfer(input int m, input logic [7:0] addr, input logic [31:0] data, input int nbits);
    snap_counts();
    addr_ones = 1'b1;
    rx_word   = '0;
    en_seen   = 1'b0;
    @(negedge clk);
    cs_n[m] = 1'b0;
    #(H);
    spi_bits(m, {addr, data}, 0, nbits);
    #(H);
    cs_n[m] = 1'b1;
    #(4 * H);
  endtask

  initial begin
    string tag;
    rst_n  = 1'b0;
    sck    = 4'b1100;
    cs_n   = 4'b1111;
    mosi   = 1'b0;
    status = {32'hA5A5A5A5, 96'h0};
    repeat (8) @(negedge clk);
    check_eq("rst_regs", regs_o[0], RST_VIEW);
    check_eq("rst_miso", 128'(miso), 128'hF);
    check_eq("rst_miso_en", 128'(miso_en), 128'h0);
    check_eq("rst_strobes", 128'({wr_str[0], rd_str[0], frame_err}), 128'h0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // Mode 0 read of reg 2
    spi_xfer(0, 8'h02, 32'h0, 40);
    check_eq("rd2_data", 128'(rx_word), 128'h0034BF15);
    check_eq("rd2_addr_miso", 128'(addr_ones), 128'h1);
    check_eq("rd2_miso_en", 128'(en_seen), 128'h1);
    check_eq("rd2_rd_mask", 128'(d_mask(0, 1'b0)), 128'h4);
    check_eq("rd2_rd_total", 128'(d_total(0, 1'b0)), 128'h1);
    check_eq("idle_miso_en", 128'(miso_en[0]), 128'h0);

    // Writes and readback in every mode
    for (int m = 0; m < 4; m++) begin
      $sformat(tag, "m%0d", m);
      spi_xfer(m, 8'h81, 32'hDEADBEEF, 40);
      check_eq({tag, "_wr1_reg"}, 128'(regs_o[m][63:32]), 128'hDEADBEEF);
      check_eq({tag, "_wr1_mask"}, 128'(d_mask(m, 1'b1)), 128'h2);
      check_eq({tag, "_wr1_total"}, 128'(d_total(m, 1'b1)), 128'h1);
      check_eq({tag, "_wr1_fe"}, 128'(fe_cnt[m] - fe_base[m]), 128'h0);
      spi_xfer(m, 8'h01, 32'h0, 40);
      check_eq({tag, "_rd1_data"}, 128'(rx_word), 128'hDEADBEEF);
      check_eq({tag, "_rd1_mask"}, 128'(d_mask(m, 1'b0)), 128'h2);
    end

    // Read-only register
    spi_xfer(0, 8'h83, 32'h12345678, 40);
    check_eq("ro_wr_total", 128'(d_total(0, 1'b1)), 128'h0);
    check_eq("ro_wr_reg3", 128'(regs_o[0][127:96]), 128'hA5A5A5A5);
    spi_xfer(0, 8'h03, 32'h0, 40);
    check_eq("ro_rd_data", 128'(rx_word), 128'hA5A5A5A5);
    check_eq("ro_rd_mask", 128'(d_mask(0, 1'b0)), 128'h8);

    // Invalid index
    spi_xfer(0, 8'h10, 32'h0, 40);
    check_eq("inv_rd_data", 128'(rx_word), 128'hFFFFFFFF);
    check_eq("inv_rd_total", 128'(d_total(0, 1'b0)), 128'h0);
    spi_xfer(0, 8'h90, 32'h55AA55AA, 40);
    check_eq("inv_wr_total", 128'(d_total(0, 1'b1)), 128'h0);
    check_eq("inv_wr_regs", regs_o[0], {32'hA5A5A5A5, 32'd3456789, 32'hDEADBEEF, 32'd1234567});

    // Truncated write frame, then a normal frame
    spi_xfer(0, 8'h80, 32'hCAFEF00D, 20);
    check_eq("trunc_fe", 128'(fe_cnt[0] - fe_base[0]), 128'h1);
    check_eq("trunc_wr_total", 128'(d_total(0, 1'b1)), 128'h0);
    check_eq("trunc_reg0", 128'(regs_o[0][31:0]), 128'd1234567);
    spi_xfer(0, 8'h00, 32'h0, 40);
    check_eq("post_trunc_data", 128'(rx_word), 128'h0012D687);
    check_eq("post_trunc_fe", 128'(fe_cnt[0] - fe_base[0]), 128'h0);

    // Reset in the middle of a data phase with CS_n held low
    snap_counts();
    @(negedge clk);
    cs_n[0] = 1'b0;
    #(H);
    spi_bits(0, {8'h82, 32'h11111111}, 0, 20);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("midrst_regs", regs_o[0], RST_VIEW);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    spi_bits(0, {8'h82, 32'h11111111}, 20, 40);
    #(H);
    cs_n[0] = 1'b1;
    #(4 * H);
    check_eq("midrst_wr_total", 128'(d_total(0, 1'b1)), 128'h0);
    check_eq("midrst_fe", 128'(fe_cnt[0] - fe_base[0]), 128'h0);
    check_eq("midrst_regs_after", regs_o[0], RST_VIEW);
    spi_xfer(0, 8'h01, 32'h0, 40);
    check_eq("midrst_rd1_data", 128'(rx_word), 128'h0023CACE);
    check_eq("midrst_rd1_mask", 128'(d_mask(0, 1'b0)), 128'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_regbank_slave.md
Name: spi_regbank_slave

Overview:
Parametrised SPI register-bank slave. Fully oversampled in the clk domain: SCK, CS_n and MOSI are synchronised, and all state lives on clk. It exposes NUM_REGS registers of DATA_W bits to the stepper core. It supports all four SPI modes, read-only status registers, per-register write/read strobes and truncated-frame detection.

Parameters:
DATA_W, 32, data bits per register and per frame data phase
ADDR_W, 8, address byte width; bit ADDR_W-1 = write flag (1=write, 0=read), low ADDR_W-1 bits = register index
NUM_REGS, 4, number of registers; must be ≤ 2^(ADDR_W-1)
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
RESET_VALUES, {32'd4567890,32'd3456789,32'd2345678,32'd1234567}, packed reset values, reg i at [i*DATA_W +: DATA_W]
RO_MASK, 4'b0000, bit i=1: reg i is read-only and reads i_status slice i

Ports:
clk  in  1  system clock
i_Rst_L  in  1  synchronous active-low reset
i_SPI_Clk  in  1  SPI SCK (async)
i_SPI_MOSI  in  1  SPI MOSI (async)
i_SPI_CS_n  in  1  SPI chip select, active low (async)
o_SPI_MISO  out  1  serial read data
o_SPI_MISO_En  out  1  MISO tri-state enable, 1 while synchronised CS_n low
o_regs  out  NUM_REGS*DATA_W  register contents (RO slots output i_status)
i_status  in  NUM_REGS*DATA_W  read-only source values
o_wr_strobe  out  NUM_REGS  1-cycle pulse on committed write to reg i
o_rd_strobe  out  NUM_REGS  1-cycle pulse when reg i snapshotted for read
o_frame_err  out  1  1-cycle pulse on truncated frame

Behaviour:
- One clock (clk). Reset is synchronous, active-low (i_Rst_L); all state is on clk.
- Sync and edge detection:
  - SCK, CS_n and MOSI each pass through 2 flops; edges are detected from the synced SCK.
  - sample_edge = rising when CPOL==CPHA, else falling; shift_edge = the opposite edge.
  - clk must be ≥ 8x SCK.
- Reset:
  - o_regs = RESET_VALUES (RO slots show i_status); strobes and o_frame_err = 0; o_SPI_MISO = 1; o_SPI_MISO_En = 0.
  - State = WAIT_CS if synced CS_n is low on reset exit, else IDLE.
  - Reset mid-frame discards the frame; no write or strobe.
- FSM states: IDLE, ADDR, DATA, DONE, WAIT_CS.
  - IDLE: on synced CS_n falling edge → ADDR; bit counter = 0.
  - ADDR: on each sample_edge, shift MOSI into the address register, MSB first. After ADDR_W bits → DATA; on that same clk:
    - Read frame: snapshot the addressed reg into the tx shift register (all-ones if index ≥ NUM_REGS); pulse o_rd_strobe[idx] for a valid index.
    - Write frame: tx shift register = all-ones.
  - DATA: on sample_edge, shift MOSI into rx data, MSB first. On the DATA_W-th sample → DONE. On that clk, for a write with idx < NUM_REGS and RO_MASK[idx]==0: reg updated and o_wr_strobe[idx] pulsed. Invalid or RO write is silently dropped; no strobe.
  - DONE: further SCK edges ignored; MISO = 1. On CS_n rising → IDLE.
  - CS_n rising in ADDR or DATA: pulse o_frame_err, no commit → IDLE.
  - WAIT_CS: wait for CS_n high → IDLE.
- MISO:
  - ADDR phase: 1.
  - DATA phase: tx MSB. The tx register shifts left on each shift_edge that occurs in DATA state.
  - CPHA=0: the MSB is presented immediately on entering DATA, ahead of the first data sample edge.
  - CPHA=1: the first shift_edge of DATA loads the MSB.
- Simultaneous events:
  - Last data sample and CS_n rising detected on the same clk: commit wins, no o_frame_err.
  - A commit never overlaps a snapshot; they occur in different frames.
- Latency: o_wr_strobe and the o_regs update follow the last data sample_edge at the pins by 4 clk (2 sync + 1 edge detect + 1 commit).
- Counter width: $clog2(ADDR_W+DATA_W+1).

Test Plan:
- Reset, defaults, mode 0: read addr 0x02 → MISO data = 0x0034BF15 (3456789); o_rd_strobe=4'b0100 one cycle; address phase MISO=1.
- Mode 0: write 0x81 with data 0xDEADBEEF → o_regs slice 1 = 0xDEADBEEF, o_wr_strobe=4'b0010 one cycle; following read 0x01 returns 0xDEADBEEF.
- RO_MASK=4'b1000, i_status slice 3=0xA5A5A5A5: write 0x83 with 0x12345678 → no strobe, slice 3 unchanged; read 0x03 → 0xA5A5A5A5.
- Invalid address: read 0x10 → 0xFFFFFFFF, no rd strobe; write 0x90 → no register changes.
- Truncated frame: CS_n raised after 20 of 40 bits of write 0x80 → o_frame_err one pulse, reg 0 stays 1234567. Next full frame works normally.
- Repeat the write/readback of 0x81 with 0xDEADBEEF in modes 1, 2, 3 → identical results; i_Rst_L low mid-DATA with CS_n still low → regs reset, remaining SCK ignored until CS_n toggles.
